// File: rtl/word_range_insert.sv
// Composes candidate words: a latched template with per-range characters dropped
// in at decoded positions, one word per accepted range-character set.

module wri_pos_sel #(
  parameter int CHAR_BITS  = 7,
  parameter int RANGES_MAX = 8,
  parameter int IDX_W      = 3
) (
  input  logic                                  sel,
  input  logic [IDX_W-1:0]                      idx,
  input  logic [RANGES_MAX-1:0][CHAR_BITS-1:0]  chars,
  input  logic [CHAR_BITS-1:0]                  tmpl,
  output logic [CHAR_BITS-1:0]                  ch
);
  assign ch = sel ? chars[idx] : tmpl;
endmodule

module word_range_insert #(
  parameter int CHAR_BITS      = 7,
  parameter int WORD_MAX_LEN   = 8,
  parameter int RANGES_MAX     = 8,
  parameter int RANGE_INFO_MSB = $clog2(WORD_MAX_LEN)
) (
  input  logic                                     CLK,
  input  logic                                     reset,
  input  logic [WORD_MAX_LEN*CHAR_BITS-1:0]        cfg_word,
  input  logic [RANGE_INFO_MSB:0]                  cfg_len,
  input  logic [RANGES_MAX*(RANGE_INFO_MSB+1)-1:0] cfg_range_info,
  input  logic                                     cfg_wr_en,
  output logic                                     cfg_ready,
  input  logic [RANGES_MAX*CHAR_BITS-1:0]          in_chars,
  input  logic                                     in_valid,
  input  logic                                     in_last,
  output logic                                     in_ready,
  output logic [WORD_MAX_LEN*CHAR_BITS-1:0]        out_word,
  output logic [RANGE_INFO_MSB:0]                  out_len,
  output logic                                     out_last,
  output logic                                     out_valid,
  input  logic                                     out_ready
);
  localparam int IW    = RANGE_INFO_MSB + 1;
  localparam int IDX_W = (RANGES_MAX > 1) ? $clog2(RANGES_MAX) : 1;

  typedef enum logic [1:0] {IDLE, DECODE, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic [WORD_MAX_LEN-1:0][CHAR_BITS-1:0] tmpl_q;
  logic [IW-1:0]                          len_q;
  logic [RANGES_MAX-1:0][IW-1:0]          info_q;
  logic [WORD_MAX_LEN-1:0]                sel_valid, dec_valid;
  logic [WORD_MAX_LEN-1:0][IDX_W-1:0]     sel_idx, dec_idx;
  logic [IW-1:0]                          len_eff, dec_len;
  logic [RANGES_MAX-1:0][CHAR_BITS-1:0]   chars_v;
  logic [WORD_MAX_LEN-1:0][CHAR_BITS-1:0] composed;
  logic [RANGES_MAX-1:0]                  act;
  int                                     eff [RANGES_MAX];
  int                                     top;
  logic                                   accept;

  assign chars_v   = in_chars;
  assign cfg_ready = (state == IDLE);
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  // A range may never land left of its own index; the lowest range wins a
  // shared position, so scan ranges high-to-low and let later writes override.
  always_comb begin
    dec_valid = '0;
    dec_idx   = '0;
    top       = 0;
    for (int j = 0; j < RANGES_MAX; j++) begin
      act[j] = info_q[j][RANGE_INFO_MSB];
      eff[j] = (int'(info_q[j][RANGE_INFO_MSB-1:0]) < j) ? j
                                                         : int'(info_q[j][RANGE_INFO_MSB-1:0]);
      if (act[j] && eff[j] < WORD_MAX_LEN && eff[j] + 1 > top) top = eff[j] + 1;
    end
    for (int p = 0; p < WORD_MAX_LEN; p++)
      for (int j = RANGES_MAX - 1; j >= 0; j--)
        if (act[j] && eff[j] == p) begin
          dec_valid[p] = 1'b1;
          dec_idx[p]   = IDX_W'(j);
        end
    dec_len = (top > int'(len_q)) ? IW'(top) : len_q;
  end

  for (genvar p = 0; p < WORD_MAX_LEN; p++) begin : g_pos
    wri_pos_sel #(.CHAR_BITS(CHAR_BITS), .RANGES_MAX(RANGES_MAX), .IDX_W(IDX_W)) u_sel (
      .sel  (sel_valid[p]),
      .idx  (sel_idx[p]),
      .chars(chars_v),
      .tmpl (tmpl_q[p]),
      .ch   (composed[p])
    );
  end

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cfg_wr_en) state_nx = DECODE;
      DECODE:  state_nx = RUN;
      RUN:     if (accept && in_last) state_nx = DRAIN;
      DRAIN:   if (out_valid && out_ready && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      tmpl_q    <= '0;
      len_q     <= '0;
      info_q    <= '0;
      sel_valid <= '0;
      sel_idx   <= '0;
      len_eff   <= '0;
      out_word  <= '0;
      out_len   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (cfg_ready && cfg_wr_en) begin
        tmpl_q <= cfg_word;
        len_q  <= cfg_len;
        info_q <= cfg_range_info;
      end
      if (state == DECODE) begin
        sel_valid <= dec_valid;
        sel_idx   <= dec_idx;
        len_eff   <= dec_len;
      end
      if (accept) begin
        out_word  <= composed;
        out_len   <= len_eff;
        out_last  <= in_last;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_word_range_insert.sv
// Directed + randomized bench for word_range_insert against a slot-claiming
// reference model of word composition.

module tb_word_range_insert;
  localparam int CB = 7, WL = 8, RM = 8, RI = 3, IW = 4;
  localparam int WW = WL*CB, IWW = RM*IW, LW = 4;

  logic          CLK = 1'b0, reset = 1'b1;
  logic [WW-1:0] cfg_word = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [IWW-1:0] cfg_range_info = '0;
  logic          cfg_wr_en = 1'b0, cfg_ready;
  logic [RM*CB-1:0] in_chars = '0;
  logic          in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [WW-1:0] out_word;
  logic [LW-1:0] out_len;
  logic          out_last, out_valid, out_ready = 1'b1;

  always #5 CLK = ~CLK;

  word_range_insert dut (
    .CLK(CLK), .reset(reset), .cfg_word(cfg_word), .cfg_len(cfg_len),
    .cfg_range_info(cfg_range_info), .cfg_wr_en(cfg_wr_en), .cfg_ready(cfg_ready),
    .in_chars(in_chars), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_word(out_word), .out_len(out_len), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  int vectors = 0, miscompares = 0;

  byte m_tmpl [WL];
  int  m_len;
  bit  m_act  [RM];
  int  m_pos  [RM];

  typedef struct { logic [WW-1:0] w; logic [LW-1:0] l; logic last; } exp_t;
  exp_t q[$];
  logic [IWW-1:0] info;
  logic [WW-1:0]  last_word;
  logic [LW-1:0]  last_len;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK); #1;
  endtask

  function automatic logic [WW-1:0] mk_word(input string s);
    logic [WW-1:0] w = '0;
    byte b;
    for (int i = 0; i < WL; i++) begin
      b = s[i];
      w[i*CB +: CB] = b[6:0];
    end
    return w;
  endfunction

  task automatic set_range(input int j, input bit a, input int p);
    info[j*IW +: IW] = {a, 3'(p)};
  endtask

  // Walk ranges in ascending order; the first range to claim a slot keeps it.
  task automatic model(input logic [RM*CB-1:0] ch, output logic [WW-1:0] w,
                       output logic [LW-1:0] l);
    bit taken [WL];
    int len, e;
    len = m_len;
    for (int p = 0; p < WL; p++) begin
      w[p*CB +: CB] = m_tmpl[p][6:0];
      taken[p] = 1'b0;
    end
    for (int j = 0; j < RM; j++) begin
      if (!m_act[j]) continue;
      e = (m_pos[j] < j) ? j : m_pos[j];
      if (e < WL && !taken[e]) begin
        taken[e] = 1'b1;
        w[e*CB +: CB] = ch[j*CB +: CB];
      end
      if (e < WL && e + 1 > len) len = e + 1;
    end
    l = LW'(len);
  endtask

  task automatic load_cfg(input logic [WW-1:0] w, input int len, input logic [IWW-1:0] inf);
    int n = 0;
    while (!cfg_ready && n < 50) begin step; n++; end
    chk("cfg_ready wait", 64'(cfg_ready), 64'(1));
    cfg_word = w; cfg_len = LW'(len); cfg_range_info = inf; cfg_wr_en = 1'b1;
    for (int p = 0; p < WL; p++) m_tmpl[p] = byte'(w[p*CB +: CB]);
    m_len = len;
    for (int j = 0; j < RM; j++) begin
      m_act[j] = inf[j*IW + RI];
      m_pos[j] = int'(inf[j*IW +: RI]);
    end
    step;
    cfg_wr_en = 1'b0;
    chk("decode cfg_ready", 64'(cfg_ready), 64'(0));
    chk("decode in_ready", 64'(in_ready), 64'(0));
    step;
  endtask

  task automatic next_chars(input bit fixed, input logic [RM*CB-1:0] fch);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    in_chars = fixed ? fch : r[RM*CB-1:0];
  endtask

  task automatic run_stream(input int n, input int stall_len, input bit fixed,
                            input logic [RM*CB-1:0] fch);
    int sent = 0, got = 0, cyc = 0, stall_left = 0;
    bit stall_pending, acc, held = 1'b0;
    logic [WW-1:0] held_w, ew;
    logic [LW-1:0] el;
    exp_t e;
    stall_pending = (stall_len > 0);
    next_chars(fixed, fch);
    in_valid = 1'b1; in_last = (n == 1);
    while (got < n && cyc < 300) begin
      if (stall_pending && out_valid) begin stall_left = stall_len; stall_pending = 1'b0; end
      out_ready = (stall_left == 0);
      #1;
      if (held) chk("held word", 64'(out_word), 64'(held_w));
      held = out_valid && !out_ready;
      held_w = out_word;
      if (out_valid && !out_ready) chk("in_ready stall", 64'(in_ready), 64'(0));
      if (out_valid && out_ready) begin
        chk("queue depth", 64'(q.size() > 0), 64'(1));
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("word", 64'(out_word), 64'(e.w));
          chk("len", 64'(out_len), 64'(e.l));
          chk("last", 64'(out_last), 64'(e.last));
          last_word = out_word; last_len = out_len;
          got++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        model(in_chars, ew, el);
        e.w = ew; e.l = el; e.last = in_last;
        q.push_back(e);
        sent++;
      end
      step;
      cyc++;
      if (stall_left > 0) stall_left--;
      if (acc) begin
        chk("latency", 64'(out_valid), 64'(1));
        if (sent == n) begin in_valid = 1'b0; in_last = 1'b0; end
        else begin next_chars(fixed, fch); in_last = (sent == n - 1); end
      end
    end
    chk("stream count", 64'(got), 64'(n));
    out_ready = 1'b1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("idle cfg_ready", 64'(cfg_ready), 64'(1));
    chk("idle out_valid", 64'(out_valid), 64'(0));
    chk("idle in_ready", 64'(in_ready), 64'(0));
  endtask

  initial begin
    logic [RM*CB-1:0] ch;
    logic [63:0] r;

    step; step;
    chk("rst cfg_ready", 64'(cfg_ready), 64'(1));
    chk("rst in_ready", 64'(in_ready), 64'(0));
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst out_last", 64'(out_last), 64'(0));
    chk("rst out_word", 64'(out_word), 64'(0));
    chk("rst out_len", 64'(out_len), 64'(0));
    reset = 1'b0;
    in_valid = 1'b1; #1;
    chk("idle no accept", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    step;

    // template "pass", r0 -> 4, r1 -> 5
    info = '0; set_range(0, 1, 4); set_range(1, 1, 5);
    load_cfg(mk_word("passWXYZ"), 4, info);
    ch = '0; ch[6:0] = 7'h61; ch[13:7] = 7'h62;
    run_stream(1, 0, 1'b1, ch);
    chk("pass word", 64'(last_word), 64'(mk_word("passabYZ")));
    chk("pass len", 64'(last_len), 64'(6));

    // clamp: r2 asks for position 0, lands on 2
    info = '0; set_range(2, 1, 0);
    load_cfg(mk_word("abcdEFGH"), 4, info);
    ch = '0; ch[20:14] = 7'h58;
    run_stream(1, 0, 1'b1, ch);
    chk("clamp word", 64'(last_word), 64'(mk_word("abXdEFGH")));
    chk("clamp len", 64'(last_len), 64'(4));

    // collision at 3: r0 beats r3, then r3 alone
    info = '0; set_range(0, 1, 3); set_range(3, 1, 3);
    load_cfg(mk_word("abcdEFGH"), 4, info);
    ch = '0; ch[6:0] = 7'h51; ch[27:21] = 7'h5a;
    run_stream(1, 0, 1'b1, ch);
    chk("collide r0", 64'(last_word), 64'(mk_word("abcQEFGH")));
    set_range(0, 0, 3);
    load_cfg(mk_word("abcdEFGH"), 4, info);
    run_stream(1, 0, 1'b1, ch);
    chk("collide r3", 64'(last_word), 64'(mk_word("abcZEFGH")));

    // backpressure: 3 sets, 5-cycle stall after first output
    r = {$urandom(), $urandom()};
    load_cfg(r[WW-1:0], 3, $urandom());
    run_stream(3, 5, 1'b0, '0);

    // cfg_wr_en during RUN must be ignored
    r = {$urandom(), $urandom()};
    load_cfg(r[WW-1:0], 5, $urandom());
    cfg_word = mk_word("GARBAGE!"); cfg_len = 4'd1; cfg_range_info = '1; cfg_wr_en = 1'b1;
    step;
    cfg_wr_en = 1'b0;
    chk("run cfg_ready", 64'(cfg_ready), 64'(0));
    chk("run in_ready", 64'(in_ready), 64'(1));
    run_stream(2, 1, 1'b0, '0);

    // reset mid-stream with a stalled output
    r = {$urandom(), $urandom()};
    load_cfg(r[WW-1:0], 2, $urandom());
    next_chars(1'b0, '0);
    in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b0;
    step;
    in_valid = 1'b0;
    chk("pre-rst out_valid", 64'(out_valid), 64'(1));
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("mid rst out_valid", 64'(out_valid), 64'(0));
    chk("mid rst in_ready", 64'(in_ready), 64'(0));
    chk("mid rst cfg_ready", 64'(cfg_ready), 64'(1));
    chk("mid rst out_word", 64'(out_word), 64'(0));
    out_ready = 1'b1;
    r = {$urandom(), $urandom()};
    load_cfg(r[WW-1:0], 6, $urandom());
    run_stream(2, 0, 1'b0, '0);

    for (int t = 0; t < 16; t++) begin
      r = {$urandom(), $urandom()};
      load_cfg(r[WW-1:0], $urandom_range(0, 8), $urandom());
      run_stream($urandom_range(1, 4), $urandom_range(0, 3), 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
